pipe_decode: RTL

PIPE_DECODE -- requirements
Module: pipe_decode

---
 rtl/pipe_decode.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_decode.sv
// Decode stage of a Y86-style pipeline: register file, operand forwarding
// and the decode/execute (E) pipeline register with stall and bubble control.
module pipe_decode #(
  parameter int                DATA_W   = 64,
  parameter int                NUM_REGS = 16,
  parameter logic [3:0]        RNONE    = 4'hF,
  parameter logic [3:0]        RSP_IDX  = 4'd4,
  parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(4095)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [2:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  input  logic [3:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [3:0] {
    I_HALT, I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV,
    I_OP, I_JXX, I_CALL, I_RET, I_PUSH, I_POP
  } icode_e;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] val_c;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    stat: 3'd1, icode: 4'd1, ifun: 4'd0,
    src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE,
    val_c: '0, val_a: '0, val_b: '0
  };

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [3:0]        d_dstE, d_dstM;
  logic [DATA_W-1:0] rf_a, rf_b, d_valA, d_valB;
  e_reg_t            e_q, e_next;

  function automatic logic in_file(input logic [3:0] idx);
    return (idx != RNONE) && (32'(idx) < NUM_REGS);
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      I_CMOV:  begin d_srcA = D_rA; d_dstE = D_rB; end
      I_IRMOV: d_dstE = D_rB;
      I_RMMOV: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOV: begin d_srcB = D_rB; d_dstM = D_rA; end
      I_OP:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      I_CALL:  begin d_srcB = RSP_IDX; d_dstE = RSP_IDX; end
      I_RET:   begin d_srcA = RSP_IDX; d_srcB = RSP_IDX; d_dstE = RSP_IDX; end
      I_PUSH:  begin d_srcA = D_rA; d_srcB = RSP_IDX; d_dstE = RSP_IDX; end
      I_POP:   begin
        d_srcA = RSP_IDX; d_srcB = RSP_IDX; d_dstE = RSP_IDX; d_dstM = D_rA;
      end
      default: ;
    endcase
  end

  assign rf_a     = in_file(d_srcA)  ? regs[d_srcA]  : '0;
  assign rf_b     = in_file(d_srcB)  ? regs[d_srcB]  : '0;
  assign dbg_data = in_file(dbg_idx) ? regs[dbg_idx] : '0;

  // Youngest producer wins; RNONE sources never match a forwarding tag.
  always_comb begin
    if (D_icode == I_JXX || D_icode == I_CALL) d_valA = D_valP;
    else if (d_srcA == RNONE)                  d_valA = '0;
    else if (d_srcA == e_dstE)                 d_valA = e_valE;
    else if (d_srcA == M_dstM)                 d_valA = m_valM;
    else if (d_srcA == M_dstE)                 d_valA = M_valE;
    else if (d_srcA == W_dstM)                 d_valA = W_valM;
    else if (d_srcA == W_dstE)                 d_valA = W_valE;
    else                                       d_valA = rf_a;
  end

  always_comb begin
    if (d_srcB == RNONE)       d_valB = '0;
    else if (d_srcB == e_dstE) d_valB = e_valE;
    else if (d_srcB == M_dstM) d_valB = m_valM;
    else if (d_srcB == M_dstE) d_valB = M_valE;
    else if (d_srcB == W_dstM) d_valB = W_valM;
    else if (d_srcB == W_dstE) d_valB = W_valE;
    else                       d_valB = rf_b;
  end

  // NOTE: the register file is small and architecturally must come up with a
  // known stack pointer, so it is built from flops with an async reset rather
  // than an unreset RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[RSP_IDX] <= RSP_INIT;
    end else begin
      // The later non-blocking write lands last, so W_valM wins a collision.
      if (in_file(W_dstE)) regs[W_dstE] <= W_valE;
      if (in_file(W_dstM)) regs[W_dstM] <= W_valM;
    end
  end

  assign e_next = '{
    stat: D_stat, icode: D_icode, ifun: D_ifun,
    src_a: d_srcA, src_b: d_srcB, dst_e: d_dstE, dst_m: d_dstM,
    val_c: D_valC, val_a: d_valA, val_b: d_valB
  };

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           e_q <= E_BUBBLE;
    else if (E_bubble) e_q <= E_BUBBLE;
    else if (!E_stall) e_q <= e_next;
  end

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;

endmodule
